// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the D-stage hazard scoreboard: forward-select
// encodings, default MDU latencies and the "operand not read" Tuse code.
package hazard_scoreboard_pkg;

    // Forward-select encodings driven on fwd_rs_D / fwd_rt_D
    localparam logic [1:0] FwdRf = 2'd0;
    localparam logic [1:0] FwdE  = 2'd1;
    localparam logic [1:0] FwdM  = 2'd2;

    // Default MDU busy latencies
    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

    // All-ones Tuse means the operand is never read, so it can never stall
    function automatic int unsigned tuse_none(input int unsigned t_w);
        return (32'd1 << t_w) - 32'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// Busy counter for the multi-cycle multiply/divide unit. A load sets the
// counter to the op latency; it then counts down to zero, busy while nonzero.
module hazard_scoreboard_md_busy_ctr
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic div_i,
    output logic busy_o
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = div_i ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared immediately by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall/forward controller. Tracks the destination registers of the
// E and M stage instructions with self-decrementing Tnew, compares them with
// the D instruction's sources, and adds an MDU busy interlock plus a
// stall-cycle performance counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned T_W         = 2,
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr_D,
    input  logic [ADDR_W-1:0] rt_addr_D,
    input  logic [T_W-1:0]    rs_tuse_D,
    input  logic [T_W-1:0]    rt_tuse_D,
    input  logic [ADDR_W-1:0] wr_addr_D,
    input  logic [T_W-1:0]    tnew_D,
    input  logic              md_start_D,
    input  logic              md_div_D,
    input  logic              md_use_D,
    output logic              stall,
    output logic [1:0]        fwd_rs_D,
    output logic [1:0]        fwd_rt_D,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [T_W-1:0] TuseNone = T_W'(tuse_none(T_W));

    logic [ADDR_W-1:0] e_addr_q, e_addr_d, m_addr_q, m_addr_d;
    logic [T_W-1:0]    e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic [2:0] rs_res, rt_res;
    logic       md_load;

    // Returns {stall, fwd_sel} for one source operand. The younger E entry
    // shadows the M entry completely, even when E cannot forward yet.
    function automatic logic [2:0] resolve(
        input logic [ADDR_W-1:0] src,
        input logic [T_W-1:0]    tuse,
        input logic [ADDR_W-1:0] e_addr,
        input logic [T_W-1:0]    e_tnew,
        input logic [ADDR_W-1:0] m_addr,
        input logic [T_W-1:0]    m_tnew
    );
        logic           hit;
        logic [T_W-1:0] tnew;
        logic [1:0]     sel;
        hit  = 1'b0;
        tnew = '0;
        sel  = FwdRf;
        if (src != '0 && src == e_addr) begin
            hit  = 1'b1;
            tnew = e_tnew;
            sel  = FwdE;
        end else if (src != '0 && src == m_addr) begin
            hit  = 1'b1;
            tnew = m_tnew;
            sel  = FwdM;
        end
        if (!hit) begin
            return {1'b0, FwdRf};
        end
        return {(tuse != TuseNone) && (tnew > tuse), (tnew == '0) ? sel : FwdRf};
    endfunction

    assign rs_res = resolve(rs_addr_D, rs_tuse_D, e_addr_q, e_tnew_q, m_addr_q, m_tnew_q);
    assign rt_res = resolve(rt_addr_D, rt_tuse_D, e_addr_q, e_tnew_q, m_addr_q, m_tnew_q);

    assign stall    = rs_res[2] | rt_res[2] | (md_use_D & md_busy);
    assign fwd_rs_D = rs_res[1:0];
    assign fwd_rt_D = rt_res[1:0];

    // A stalled mult/div does not start; it retries from D next cycle
    assign md_load = md_start_D & ~stall;

    hazard_scoreboard_md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (md_load),
        .div_i  (md_div_D),
        .busy_o (md_busy)
    );

    // Scoreboard advance: E ages into M, D enters E unless a bubble is inserted
    always_comb begin
        m_addr_d = e_addr_q;
        m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - 1'b1;
        e_addr_d = stall ? '0 : wr_addr_D;
        e_tnew_d = stall ? '0 : tnew_D;
        stall_count_d = stall ? stall_count_q + 1'b1 : stall_count_q;
    end

    // Scoreboard and performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_addr_q      <= '0;
            e_tnew_q      <= '0;
            m_addr_q      <= '0;
            m_tnew_q      <= '0;
            stall_count_q <= '0;
        end else begin
            e_addr_q      <= e_addr_d;
            e_tnew_q      <= e_tnew_d;
            m_addr_q      <= m_addr_d;
            m_tnew_q      <= m_tnew_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios followed by random
// traffic, all checked against a model that tracks in-flight producers by the
// edge at which they entered E.
module tb_hazard_scoreboard;

    localparam int CntW   = 4;
    localparam int MultLat = 5;
    localparam int DivLat  = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [4:0]      rs_addr_D = '0, rt_addr_D = '0, wr_addr_D = '0;
    logic [1:0]      rs_tuse_D = '0, rt_tuse_D = '0, tnew_D = '0;
    logic            md_start_D = 1'b0, md_div_D = 1'b0, md_use_D = 1'b0;
    logic            stall, md_busy;
    logic [1:0]      fwd_rs_D, fwd_rt_D;
    logic [CntW-1:0] stall_count;

    hazard_scoreboard #(
        .CNT_W (CntW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_addr_D   (rs_addr_D),
        .rt_addr_D   (rt_addr_D),
        .rs_tuse_D   (rs_tuse_D),
        .rt_tuse_D   (rt_tuse_D),
        .wr_addr_D   (wr_addr_D),
        .tnew_D      (tnew_D),
        .md_start_D  (md_start_D),
        .md_div_D    (md_div_D),
        .md_use_D    (md_use_D),
        .stall       (stall),
        .fwd_rs_D    (fwd_rs_D),
        .fwd_rt_D    (fwd_rt_D),
        .md_busy     (md_busy),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each producer that left D is remembered with the edge number at which it
    // entered E. Age 0 = in E, age 1 = in M, older = gone. Remaining latency is
    // its Tnew minus its age, floored at zero.
    typedef struct {
        int addr;
        int tnew;
        int entered;
    } rec_t;

    rec_t rec_q[$];
    int   n_edge  = 0;
    int   md_done = 0;
    int   cnt_m   = 0;

    function automatic void model_operand(input int src, input int tuse,
                                          output bit stl, output int fwd);
        stl = 1'b0;
        fwd = 0;
        if (src == 0) return;
        for (int i = rec_q.size() - 1; i >= 0; i--) begin
            int age;
            int rem;
            age = n_edge - rec_q[i].entered;
            if (age <= 1 && rec_q[i].addr == src) begin
                rem = rec_q[i].tnew - age;
                if (rem < 0) rem = 0;
                stl = (tuse != 3) && (rem > tuse);
                fwd = (rem == 0) ? ((age == 0) ? 1 : 2) : 0;
                return;
            end
        end
    endfunction

    function automatic void model_eval(output bit s, output int fr, output int ft, output bit b);
        bit srs, srt;
        model_operand(int'(rs_addr_D), int'(rs_tuse_D), srs, fr);
        model_operand(int'(rt_addr_D), int'(rt_tuse_D), srt, ft);
        b = (n_edge < md_done);
        s = srs | srt | (md_use_D && b);
    endfunction

    function automatic void model_update();
        bit s, b;
        int fr, ft;
        model_eval(s, fr, ft, b);
        n_edge++;
        if (!s && wr_addr_D != 0) rec_q.push_back('{int'(wr_addr_D), int'(tnew_D), n_edge});
        if (md_start_D && !s) md_done = n_edge + (md_div_D ? DivLat : MultLat);
        if (s) cnt_m = (cnt_m + 1) % (1 << CntW);
        while (rec_q.size() > 0 && n_edge - rec_q[0].entered >= 2) void'(rec_q.pop_front());
    endfunction

    function automatic void model_reset();
        rec_q.delete();
        md_done = n_edge;
        cnt_m   = 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int rs, input int rs_tu, input int rt, input int rt_tu,
                         input int wr, input int tn, input bit start, input bit dv,
                         input bit use_md);
        rs_addr_D  = 5'(rs);
        rs_tuse_D  = 2'(rs_tu);
        rt_addr_D  = 5'(rt);
        rt_tuse_D  = 2'(rt_tu);
        wr_addr_D  = 5'(wr);
        tnew_D     = 2'(tn);
        md_start_D = start;
        md_div_D   = dv;
        md_use_D   = use_md;
    endtask

    // One clock cycle: compare all outputs to the model mid-cycle, then clock.
    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(output bit s_o, output int fr_o, output int ft_o, output bit b_o);
        bit s, b;
        int fr, ft;
        @(negedge clk);
        model_eval(s, fr, ft, b);
        check_eq("stall", 32'(stall), 32'(s));
        check_eq("fwd_rs", 32'(fwd_rs_D), 32'(fr));
        check_eq("fwd_rt", 32'(fwd_rt_D), 32'(ft));
        check_eq("md_busy", 32'(md_busy), 32'(b));
        check_eq("stall_count", 32'(stall_count), 32'(cnt_m));
        s_o  = stall;
        fr_o = int'(fwd_rs_D);
        ft_o = int'(fwd_rt_D);
        b_o  = md_busy;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset pulse in the low phase of the clock
    task automatic reset_pulse(input string tag);
        bit s, b;
        int fr, ft;
        @(negedge clk);
        model_eval(s, fr, ft, b);
        check_eq({tag, "_pre_busy"}, 32'(md_busy), 32'(b));
        check_eq({tag, "_pre_stall"}, 32'(stall), 32'(s));
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_eq({tag, "_busy"}, 32'(md_busy), 32'd0);
        check_eq({tag, "_stall"}, 32'(stall), 32'd0);
        check_eq({tag, "_count"}, 32'(stall_count), 32'd0);
        check_eq({tag, "_fwd"}, 32'({fwd_rs_D, fwd_rt_D}), 32'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Hold mflo in D until it stops stalling; check stall and busy lengths
    task automatic mflo_run(input string tag, input int exp_len);
        bit s, b;
        int fr, ft, st, bz;
        st = 0;
        bz = 0;
        drive(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(s, fr, ft, b);
            if (b) bz++;
            if (!s) break;
            st++;
        end
        check_eq({tag, "_stall_len"}, 32'(st), 32'(exp_len));
        check_eq({tag, "_busy_len"}, 32'(bz), 32'(exp_len));
    endtask

    // lw $8; add $11, $8 -> one-cycle stall then no forward needed from M
    task automatic load_use();
        bit s, b;
        int fr, ft;
        drive(0, 3, 0, 3, 8, 2, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        drive(8, 1, 0, 3, 11, 1, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        check_eq("lu_stall", 32'(s), 32'd1);
        cycle(s, fr, ft, b);
        check_eq("lu_after_stall", 32'(s), 32'd0);
        check_eq("lu_after_fwd", 32'(fr), 32'd0);
    endtask

    initial begin
        bit s, b;
        int fr, ft;

        // Reset state
        #2;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_fwd", 32'({fwd_rs_D, fwd_rt_D}), 32'd0);
        check_eq("rst_busy", 32'(md_busy), 32'd0);
        check_eq("rst_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        model_update();
        #1;

        load_use();

        // addu $9 (Tnew 1) then beq reading $9 (Tuse 0)
        drive(0, 3, 0, 3, 9, 1, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        drive(9, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        check_eq("br_stall", 32'(s), 32'd1);
        cycle(s, fr, ft, b);
        check_eq("br_fwd_m", 32'(fr), 32'd2);
        check_eq("br_no_stall", 32'(s), 32'd0);

        // Both E and M write $10 with Tnew 0: E wins
        drive(0, 3, 0, 3, 10, 0, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        cycle(s, fr, ft, b);
        drive(0, 0, 10, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        check_eq("prio_fwd_e", 32'(ft), 32'd1);
        check_eq("prio_stall", 32'(s), 32'd0);
        // Register $0 written with a late result never matches
        drive(0, 3, 0, 3, 0, 2, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        check_eq("r0_stall", 32'(s), 32'd0);
        check_eq("r0_fwd", 32'(ft), 32'd0);

        // mult then mflo; div then mflo
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b0, 1'b1);
        cycle(s, fr, ft, b);
        mflo_run("mult", MultLat);
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        cycle(s, fr, ft, b);
        mflo_run("div", DivLat);

        // Unrelated addu behind a mult proceeds
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b0, 1'b1);
        cycle(s, fr, ft, b);
        drive(1, 1, 2, 1, 3, 1, 1'b0, 1'b0, 1'b0);
        cycle(s, fr, ft, b);
        check_eq("indep_stall", 32'(s), 32'd0);
        check_eq("indep_busy", 32'(b), 32'd1);
        mflo_run("mult_tail", MultLat - 1);

        // Reset while the div counter holds 6, with mflo waiting in D
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        cycle(s, fr, ft, b);
        drive(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(s, fr, ft, b);
        check_eq("div_busy_before_rst", 32'(b), 32'd1);
        drive(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b1);
        reset_pulse("mid_div_rst");
        cycle(s, fr, ft, b);
        check_eq("mflo_after_rst", 32'(s), 32'd0);

        // 17 stall cycles on a 4-bit counter wrap to 1
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        cycle(s, fr, ft, b);
        mflo_run("wrap_div", DivLat);
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b0, 1'b1);
        cycle(s, fr, ft, b);
        mflo_run("wrap_mult", MultLat);
        load_use();
        load_use();
        check_eq("wrap_count", 32'(stall_count), 32'd1);

        // Random traffic on a small register set so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            bit st;
            st = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  st, 1'($urandom_range(0, 1)), st | ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 199) == 0) reset_pulse("rand_rst");
            else cycle(s, fr, ft, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, expected finish before 1000000");
        $fatal(1, "bench timeout");
    end

endmodule
